// File: rtl/display_pkg.sv
`default_nettype none
//==============================================================================
// Module : display_pkg
// Brief  : Shared FSM states, digit codes, segment patterns and BCD helper.
// Rev    : 1.0 - initial release
//==============================================================================
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Internal digit codes: 0-9 are numerals, plus two symbols.
    localparam logic [3:0] c_DIG_DASH  = 4'hA;
    localparam logic [3:0] c_DIG_BLANK = 4'hF;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] c_SEG_0     = 7'h40;
    localparam logic [6:0] c_SEG_1     = 7'h79;
    localparam logic [6:0] c_SEG_2     = 7'h24;
    localparam logic [6:0] c_SEG_3     = 7'h30;
    localparam logic [6:0] c_SEG_4     = 7'h19;
    localparam logic [6:0] c_SEG_5     = 7'h12;
    localparam logic [6:0] c_SEG_6     = 7'h02;
    localparam logic [6:0] c_SEG_7     = 7'h78;
    localparam logic [6:0] c_SEG_8     = 7'h00;
    localparam logic [6:0] c_SEG_9     = 7'h10;
    localparam logic [6:0] c_SEG_DASH  = 7'h3F;
    localparam logic [6:0] c_SEG_BLANK = 7'h7F;

    // "0" on the rightmost digit, everything else dark.
    localparam logic [31:0] c_BUF_RESET = 32'hFFFF_FFF0;

    // A sign needs one of the eight positions, leaving seven for magnitude.
    localparam logic [24:0] c_NEG_MAX = 25'd9999999;

    // One double-dabble step: correct nibbles >= 5, then shift {bcd, bin} left.
    function automatic logic [56:0] dabble_step(input logic [31:0] bcd,
                                                input logic [24:0] bin);
        logic [31:0] adj;
        adj = bcd;
        for (int n = 0; n < 8; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
            end
        end
        return {adj[30:0], bin, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_encode.sv
`default_nettype none
//==============================================================================
// Module : seg7_encode
// Brief  : Digit code to active-low seven-segment pattern (combinational).
// Rev    : 1.0 - initial release
//==============================================================================
module seg7_encode
    import display_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_SEG_BLANK;
        case (i_digit)
            4'd0:       o_seg = c_SEG_0;
            4'd1:       o_seg = c_SEG_1;
            4'd2:       o_seg = c_SEG_2;
            4'd3:       o_seg = c_SEG_3;
            4'd4:       o_seg = c_SEG_4;
            4'd5:       o_seg = c_SEG_5;
            4'd6:       o_seg = c_SEG_6;
            4'd7:       o_seg = c_SEG_7;
            4'd8:       o_seg = c_SEG_8;
            4'd9:       o_seg = c_SEG_9;
            c_DIG_DASH: o_seg = c_SEG_DASH;
            default:    o_seg = c_SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
//==============================================================================
// Module : seg7_scan_driver
// Brief  : Signed-magnitude to BCD converter driving a multiplexed 8-digit
//          seven-segment display.
// Rev    : 1.0 - initial release
//==============================================================================
module seg7_scan_driver
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [24:0] abs_num,
    input  logic        neg,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic [31:0] bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic        ovf
);

    localparam int              c_CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_SCAN_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [4:0]      c_LAST_STEP = 5'd24;

    state_t              r_state;
    logic                r_load;
    logic [4:0]          r_step;
    logic                r_snap_neg;
    logic [24:0]         r_snap_num;
    logic [24:0]         r_bin_work;
    logic [31:0]         r_bcd_work;
    logic [31:0]         r_bcd;
    logic                r_bcd_valid;
    logic                r_busy;
    logic                r_ovf;
    logic [7:0][3:0]     r_buf;

    logic [56:0]         w_step;
    logic [31:0]         w_bcd_final;
    logic                w_ovf;
    logic [7:0][3:0]     w_buf;
    int                  w_msd;

    logic [c_CNT_W-1:0]  r_scan_cnt;
    logic [2:0]          r_idx;
    logic [7:0]          r_an;
    logic [6:0]          r_seg;
    logic [3:0]          w_cur_code;
    logic [6:0]          w_cur_seg;

    assign w_step      = dabble_step(r_bcd_work, r_bin_work);
    assign w_bcd_final = w_step[56:25];
    assign w_ovf       = r_snap_neg && (r_snap_num > c_NEG_MAX);

    // Display image of the value finishing conversion this cycle.
    always_comb begin
        w_msd = 0;
        w_buf = {8{c_DIG_BLANK}};
        for (int i = 1; i < 8; i++) begin
            if (w_bcd_final[i*4 +: 4] != 4'd0) begin
                w_msd = i;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (w_ovf) begin
                w_buf[i] = c_DIG_DASH;
            end else if (i <= w_msd) begin
                w_buf[i] = w_bcd_final[i*4 +: 4];
            end else if (r_snap_neg && (i == w_msd + 1)) begin
                w_buf[i] = c_DIG_DASH;
            end else begin
                w_buf[i] = c_DIG_BLANK;
            end
        end
    end

    // Conversion FSM. Capture happens in IDLE; work registers load from the
    // snapshot on the following edge, so a stable snapshot feeds every step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_load      <= 1'b0;
            r_step      <= 5'd0;
            r_snap_neg  <= 1'b0;
            r_snap_num  <= 25'd0;
            r_bin_work  <= 25'd0;
            r_bcd_work  <= 32'd0;
            r_bcd       <= 32'd0;
            r_bcd_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ovf       <= 1'b0;
            r_buf       <= c_BUF_RESET;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_load) begin
                        r_load     <= 1'b0;
                        r_bin_work <= r_snap_num;
                        r_bcd_work <= 32'd0;
                        r_step     <= 5'd0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end else if ({neg, abs_num} != {r_snap_neg, r_snap_num}) begin
                        r_snap_neg <= neg;
                        r_snap_num <= abs_num;
                        r_load     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_bcd_work <= w_step[56:25];
                    r_bin_work <= w_step[24:0];
                    if (r_step == c_LAST_STEP) begin
                        // Results become visible for the single DONE cycle.
                        r_bcd       <= w_bcd_final;
                        r_bcd_valid <= 1'b1;
                        r_ovf       <= w_ovf;
                        r_buf       <= w_buf;
                        r_state     <= ST_DONE;
                    end else begin
                        r_step <= r_step + 5'd1;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_cur_code = r_buf[r_idx];

    seg7_encode u_seg7_encode (
        .i_digit (w_cur_code),
        .o_seg   (w_cur_seg)
    );

    // Scan timing runs free of the converter; a digit's pattern is latched
    // once at the start of its slot so buffer updates land on the next digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= 3'd0;
            r_an       <= 8'hFF;
            r_seg      <= c_SEG_BLANK;
        end else begin
            if (r_scan_cnt == c_SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            if (r_scan_cnt == '0) begin
                r_an  <= ~(8'd1 << r_idx);
                r_seg <= w_cur_seg;
            end
        end
    end

    assign an        = r_an;
    assign seg       = r_seg;
    assign bcd       = r_bcd;
    assign bcd_valid = r_bcd_valid;
    assign busy      = r_busy;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
//==============================================================================
// Module : tb_seg7_scan_driver
// Brief  : Vector table, hand sequences and random values against a decimal
//          reference model of the display.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_seg7_scan_driver;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [24:0] abs_num = 25'd0;
    logic        neg = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [31:0] bcd;
    logic        bcd_valid;
    logic        busy;
    logic        ovf;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [24:0] num;
        logic        ng;
        logic [31:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [8];

    seg7_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abs_num   (abs_num),
        .neg       (neg),
        .an        (an),
        .seg       (seg),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] digit_seg(input int unsigned v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    function automatic logic [31:0] model_bcd(input int unsigned num);
        logic [31:0] r;
        int unsigned t;
        t = num;
        for (int d = 0; d < 8; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input int unsigned num, input logic ng);
        return ng && (num > 9999999);
    endfunction

    // Eight 7-bit patterns, digit d at bits [d*7 +: 7].
    function automatic logic [55:0] model_disp(input int unsigned num, input logic ng);
        logic [55:0] r;
        int unsigned t;
        int nd;
        nd = 1;
        t = num / 10;
        while (t != 0) begin
            nd++;
            t = t / 10;
        end
        t = num;
        for (int d = 0; d < 8; d++) begin
            if (model_ovf(num, ng))       r[d*7 +: 7] = 7'h3F;
            else if (d < nd)              r[d*7 +: 7] = digit_seg(t % 10);
            else if (ng && d == nd)       r[d*7 +: 7] = 7'h3F;
            else                          r[d*7 +: 7] = 7'h7F;
            t = t / 10;
        end
        return r;
    endfunction

    // Counts rising edges until bcd_valid is seen; -1 when the bound expires.
    task automatic wait_valid(output int cycles, input int limit);
        int c;
        bit seen;
        c = 0;
        seen = 1'b0;
        while (!seen && c < limit) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            if (bcd_valid) seen = 1'b1;
        end
        cycles = seen ? c : -1;
    endtask

    task automatic convert(input int unsigned num, input logic ng, input int exp_lat);
        int lat;
        @(negedge clk);
        abs_num = 25'(num);
        neg = ng;
        wait_valid(lat, 60);
        check("latency", 32'(lat), 32'(exp_lat));
        check("bcd", bcd, model_bcd(num));
        check("ovf", {31'd0, ovf}, {31'd0, model_ovf(num, ng)});
        check("busy_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("valid_pulse", {31'd0, bcd_valid}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_display(input int unsigned num, input logic ng);
        logic [55:0] exp;
        logic [7:0]  want;
        int k;
        exp = model_disp(num, ng);
        repeat (40) @(negedge clk);
        for (int d = 0; d < 8; d++) begin
            want = ~(8'd1 << d);
            k = 0;
            while (an !== want && k < 40) begin
                @(negedge clk);
                k++;
            end
            check($sformatf("an_d%0d", d), {24'd0, an}, {24'd0, want});
            check($sformatf("seg_d%0d", d), {25'd0, seg}, {25'd0, exp[d*7 +: 7]});
        end
    endtask

    initial begin
        int lat;
        int k;
        int unsigned rnum;
        logic rneg;
        int unsigned prev_num;
        logic prev_neg;

        vecs[0] = '{25'd12345,    1'b0, 32'h00012345, 1'b0};
        vecs[1] = '{25'd0,        1'b1, 32'h00000000, 1'b0};
        vecs[2] = '{25'd9999999,  1'b1, 32'h09999999, 1'b0};
        vecs[3] = '{25'd10000000, 1'b1, 32'h10000000, 1'b1};
        vecs[4] = '{25'd33554431, 1'b0, 32'h33554431, 1'b0};
        vecs[5] = '{25'd7,        1'b1, 32'h00000007, 1'b0};
        vecs[6] = '{25'd1000,     1'b0, 32'h00001000, 1'b0};
        vecs[7] = '{25'd0,        1'b0, 32'h00000000, 1'b0};

        // Reset state
        #12;
        check("rst_an", {24'd0, an}, 32'hFF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bcd", bcd, 32'd0);
        check("rst_valid", {31'd0, bcd_valid}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);

        // Idle scan with 0/0: digit steps every SCAN_DIV cycles, no conversion
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("scan_an", {24'd0, an}, {24'd0, ~(8'd1 << (((c - 1) / SCAN_DIV) % 8))});
            check("scan_seg", {25'd0, seg}, ((((c - 1) / SCAN_DIV) % 8) == 0) ? 32'h40 : 32'h7F);
            check("scan_busy", {31'd0, busy}, 32'd0);
        end

        // Vector table
        for (int v = 0; v < 8; v++) begin
            convert(vecs[v].num, vecs[v].ng, 27);
            check("tbl_bcd", bcd, vecs[v].exp_bcd);
            check("tbl_ovf", {31'd0, ovf}, {31'd0, vecs[v].exp_ovf});
            check_display(vecs[v].num, vecs[v].ng);
        end

        // Input change during SHIFT is held off until the next IDLE
        @(negedge clk);
        abs_num = 25'd100;
        neg = 1'b0;
        k = 0;
        while (!busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("busy_start", {31'd0, busy}, 32'd1);
        repeat (5) @(negedge clk);
        abs_num = 25'd200;
        wait_valid(lat, 60);
        check("first_bcd", bcd, 32'h100);
        wait_valid(lat, 60);
        check("second_gap", 32'(lat), 32'd28);
        check("second_bcd", bcd, 32'h200);
        check_display(200, 1'b0);

        // Asynchronous reset in the middle of a conversion
        @(negedge clk);
        abs_num = 25'd4242;
        neg = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_an", {24'd0, an}, 32'hFF);
        check("arst_seg", {25'd0, seg}, 32'h7F);
        check("arst_bcd", bcd, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("arst_valid", {31'd0, bcd_valid}, 32'd0);
        end
        rst_n = 1'b1;
        wait_valid(lat, 60);
        check("restart_lat", 32'(lat), 32'd27);
        check("restart_bcd", bcd, 32'h4242);
        check_display(4242, 1'b1);

        // Random values against the decimal model
        prev_num = 4242;
        prev_neg = 1'b1;
        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 2))
                0:       rnum = $urandom_range(0, 99999);
                1:       rnum = $urandom_range(9999990, 10000010);
                default: rnum = $urandom & 32'h01FF_FFFF;
            endcase
            rneg = 1'($urandom_range(0, 1));
            if (rnum == prev_num && rneg == prev_neg) rneg = ~rneg;
            convert(rnum, rneg, 27);
            check_display(rnum, rneg);
            prev_num = rnum;
            prev_neg = rneg;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
